// File: rtl/sprite_ram_writer.sv
// Bus-side loader for the 2bpp sprite RAMs: unpacks 32-bit bus words into pixel writes.
// Optional whole-RAM fill command is enabled by defining SPRITE_WR_FILL_EN.
module sprite_ram_writer #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cs,
  input  logic                  write,
  input  logic [1:0]            reg_addr,
  input  logic [31:0]           wr_data,
  output logic [31:0]           rd_data,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr_w,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  busy
);

  localparam int PIX_PER_WORD = 32 / DATA_WIDTH;
  localparam int IDX_W        = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;

  localparam logic [1:0] REG_PTR  = 2'd0;
  localparam logic [1:0] REG_DATA = 2'd1;
  localparam logic [1:0] REG_FILL = 2'd2;
  localparam logic [1:0] REG_CLR  = 2'd3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_UNPACK = 2'd1;
`ifdef SPRITE_WR_FILL_EN
  localparam logic [1:0] ST_FILL   = 2'd2;
`endif

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [IDX_W-1:0]      IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(PIX_PER_WORD - 1);

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [31:0]           r_word;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_last;
  logic                  r_ovf;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_din;
`ifdef SPRITE_WR_FILL_EN
  logic [ADDR_WIDTH-1:0] r_faddr;
  logic [DATA_WIDTH-1:0] r_fill_val;
`endif

  logic                  w_wr;
  logic                  w_busy;
  logic                  w_drop;
  logic                  w_clr;
  logic [DATA_WIDTH-1:0] w_pix;

  assign w_wr   = cs && write;
  assign w_busy = (r_state != ST_IDLE);
  assign w_clr  = w_wr && (reg_addr == REG_CLR);
  assign w_pix  = r_word[DATA_WIDTH*r_idx +: DATA_WIDTH];

  // Without the fill feature, reg 2 is a dead register and never flags an overflow.
`ifdef SPRITE_WR_FILL_EN
  assign w_drop = w_wr && w_busy && (reg_addr != REG_CLR);
`else
  assign w_drop = w_wr && w_busy && ((reg_addr == REG_PTR) || (reg_addr == REG_DATA));
`endif

  // NOTE: every register, datapath included, sits on the async reset so an abort
  // leaves no stale word or address behind; state updates use <= so all registers
  // sample the same pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_word  <= '0;
      r_idx   <= '0;
      r_last  <= 1'b0;
      r_ovf   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_din   <= '0;
`ifdef SPRITE_WR_FILL_EN
      r_faddr    <= '0;
      r_fill_val <= '0;
`endif
    end else begin
      r_we <= 1'b0;

      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (w_clr) begin
        r_ovf <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_wr && (reg_addr == REG_PTR)) begin
            r_ptr <= wr_data[ADDR_WIDTH-1:0];
          end else if (w_wr && (reg_addr == REG_DATA)) begin
            // Pixel 0 goes out on the accepting edge so the first ram_we has no bubble.
            r_word  <= wr_data;
            r_we    <= 1'b1;
            r_addr  <= r_ptr;
            r_din   <= wr_data[DATA_WIDTH-1:0];
            r_ptr   <= r_ptr + ADDR_ONE;
            r_idx   <= IDX_ONE;
            r_last  <= (PIX_PER_WORD == 1);
            r_state <= ST_UNPACK;
          end
`ifdef SPRITE_WR_FILL_EN
          else if (w_wr && (reg_addr == REG_FILL)) begin
            r_fill_val <= wr_data[DATA_WIDTH-1:0];
            r_we       <= 1'b1;
            r_addr     <= '0;
            r_din      <= wr_data[DATA_WIDTH-1:0];
            r_faddr    <= ADDR_ONE;
            r_last     <= 1'b0;
            r_state    <= ST_FILL;
          end
`endif
        end

        ST_UNPACK: begin
          if (r_last) begin
            r_last  <= 1'b0;
            r_idx   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_we   <= 1'b1;
            r_addr <= r_ptr;
            r_din  <= w_pix;
            r_ptr  <= r_ptr + ADDR_ONE;
            r_idx  <= r_idx + IDX_ONE;
            r_last <= (r_idx == IDX_LAST);
          end
        end

`ifdef SPRITE_WR_FILL_EN
        ST_FILL: begin
          if (r_last) begin
            r_last  <= 1'b0;
            r_faddr <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_we    <= 1'b1;
            r_addr  <= r_faddr;
            r_din   <= r_fill_val;
            r_faddr <= r_faddr + ADDR_ONE;
            r_last  <= (r_faddr == {ADDR_WIDTH{1'b1}});
          end
        end
`endif

        default: begin
          r_last  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // NOTE: rd_data is given a default before the case so no latch is inferred.
  always_comb begin
    rd_data = '0;
    case (reg_addr)
      REG_PTR:  rd_data[ADDR_WIDTH-1:0] = r_ptr;
      REG_DATA: rd_data[1:0]            = {r_ovf, w_busy};
      default:  rd_data                 = '0;
    endcase
  end

  assign ram_we     = r_we;
  assign ram_addr_w = r_addr;
  assign ram_din    = r_din;
  assign busy       = w_busy;

endmodule
